rename_stage: RTL and testbench
===============================

// Module: rename_stage
// PURPOSE
//   Register-rename stage directly downstream of the decode skid buffer in OoO_top.
//   Maps the architectural rs1/rs2/rd of each decoded instruction to physical registers.
//   Uses a 32-entry speculative RAT and a FIFO free list; allocates a new physical rd per writer.
//   Registers the result in a single output stage with valid/ready backpressure toward dispatch/ROB.
//   Physical registers freed at commit return to the free list.
// PARAMETERS
//   T         logic [31:0]          data/immediate type, passed through unchanged
//   NUM_PREGS 64                    physical register count; must be > 32
//   PREG_W    $clog2(NUM_PREGS)     physical tag width (derived)
//   FL_DEPTH  NUM_PREGS-32          free-list capacity (derived)
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       asynchronous, active-high reset
//   i_valid        in   1       decoded instruction valid (from skid buffer)
//   o_ready        out  1       stage can accept an instruction this cycle
//   i_pc           in   9       instruction PC
//   i_rs1/i_rs2/i_rd in 5 each  architectural register indices
//   i_immediate    in   T       decoded immediate
//   i_ALUsrc, i_Branch, i_Memread, i_Memwrite, i_Regwrite  in 1 each  decode controls
//   i_ALUOp        in   2       ALU op class
//   i_FUtype       in   2       00 ALU, 01 branch, 10 LSU
//   o_valid        out  1       renamed instruction valid
//   i_ready        in   1       downstream accepts this cycle
//   o_pc, o_immediate, o_ALUsrc, o_Branch, o_ALUOp, o_FUtype, o_Memread, o_Memwrite, o_Regwrite
//                  out  =in     registered copies of the inputs
//   o_prs1/o_prs2  out  PREG_W  physical sources
//   o_prd          out  PREG_W  allocated physical destination (0 if none)
//   o_old_prd      out  PREG_W  previous mapping of rd, freed by ROB at commit (0 if none)
//   i_commit_valid in   1       ROB returns a physical register this cycle
//   i_commit_preg  in   PREG_W  physical register being freed
// BEHAVIOUR
//   Reset, asynchronous:
//     RAT[i]=i for i=0..31; free list = {32..NUM_PREGS-1} in ascending order.
//     Head=0, count=FL_DEPTH; o_valid=0; all data outputs 0.
//   o_ready = (!o_valid || i_ready) && (fl_count != 0). It does not depend on i_Regwrite.
//   Accept = i_valid && o_ready. On accept the output register loads at the next edge (latency 1).
//   Source mapping: o_prs1=RAT[i_rs1], o_prs2=RAT[i_rs2], read before this instruction's RAT update.
//     rs==rd in the same instruction therefore sees the old mapping.
//     The previous instruction's update is already visible, so no bypass is needed.
//   Allocation when i_Regwrite && i_rd!=0:
//     o_prd=free-list head; o_old_prd=RAT[i_rd]; RAT[i_rd]<=o_prd; pop the free list.
//   Otherwise o_prd=0, o_old_prd=0, no pop, RAT unchanged. x0 always maps to preg 0.
//   Hold: o_valid && !i_ready -> all outputs stay stable and no RAT or free-list change.
//   Drain: if i_ready and there is no accept, o_valid<=0.
//   Commit push: i_commit_valid && i_commit_preg!=0 writes the tail (tail wraps at FL_DEPTH-1 -> 0).
//     Commit of preg 0 is ignored.
//     A freed register becomes poppable the next cycle; there is no same-cycle bypass.
//     If o_ready is 0 only because the list is empty, o_ready rises the cycle after the push.
//   Push and pop in the same cycle: count unchanged, both pointers advance.
//   Push when count==FL_DEPTH is illegal: simulation assertion fires, push is dropped.
//   The free-list FIFO is not power-of-2 sized; wrap is explicit.
// TESTING
//   1 After reset, ADD x1,x2,x3 -> next cycle o_valid=1, prs1=2, prs2=3, prd=32, old_prd=1.
//   2 ADD x1 then ADDI x4,x1,100 back-to-back -> second: prs1=32, prd=33, old_prd=4.
//   3 SW x8,12(x9) and ADDI x0,x0,1 -> prd=0, old_prd=0, free count unchanged (32).
//   4 32 writers, no commits -> o_ready=0 after the 32nd accept.
//     Then commit preg 1 -> o_ready=1 the next cycle; next writer gets prd=1.
//   5 i_ready=0 while o_valid=1 for 5 cycles -> outputs stable, o_ready=0, RAT unchanged.
//     Then i_ready=1 -> stream resumes with no loss or duplication.
//   6 Assert rst mid-stream (async, off-edge) -> o_valid=0 immediately; afterwards RAT is identity,
//     free count is 32, and the next writer gets prd=32.

Source files
------------

// File: rtl/rename_stage.sv
// Register-rename stage: a speculative RAT and a FIFO free list feed one registered
// output slot with valid/ready backpressure toward dispatch/ROB.
module rename_stage #(
  parameter type T         = logic [31:0],
  parameter int  NUM_PREGS = 64,
  parameter int  PREG_W    = $clog2(NUM_PREGS),
  parameter int  FL_DEPTH  = NUM_PREGS - 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [8:0]        i_pc,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [4:0]        i_rd,
  input  T                  i_immediate,
  input  logic              i_ALUsrc,
  input  logic              i_Branch,
  input  logic              i_Memread,
  input  logic              i_Memwrite,
  input  logic              i_Regwrite,
  input  logic [1:0]        i_ALUOp,
  input  logic [1:0]        i_FUtype,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [8:0]        o_pc,
  output T                  o_immediate,
  output logic              o_ALUsrc,
  output logic              o_Branch,
  output logic [1:0]        o_ALUOp,
  output logic [1:0]        o_FUtype,
  output logic              o_Memread,
  output logic              o_Memwrite,
  output logic              o_Regwrite,
  output logic [PREG_W-1:0] o_prs1,
  output logic [PREG_W-1:0] o_prs2,
  output logic [PREG_W-1:0] o_prd,
  output logic [PREG_W-1:0] o_old_prd,
  input  logic              i_commit_valid,
  input  logic [PREG_W-1:0] i_commit_preg
);

  localparam int IDX_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int CNT_W = $clog2(FL_DEPTH + 1);

  logic [PREG_W-1:0] rat_reg [32];
  logic [PREG_W-1:0] fl_reg [FL_DEPTH];
  logic [IDX_W-1:0]  head_reg, head_next;
  logic [IDX_W-1:0]  tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic              accept;
  logic              alloc;
  logic              push;
  logic              fl_full;
  logic [PREG_W-1:0] alloc_preg;

  assign o_ready    = (!o_valid || i_ready) && (count_reg != '0);
  assign accept     = i_valid && o_ready;
  assign alloc      = accept && i_Regwrite && (i_rd != 5'd0);
  assign fl_full    = (count_reg == CNT_W'(FL_DEPTH));
  assign push       = i_commit_valid && (i_commit_preg != '0) && !fl_full;
  assign alloc_preg = fl_reg[head_reg];

  // Depth need not be a power of two, so both pointers wrap explicitly.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (alloc)
      head_next = (head_reg == IDX_W'(FL_DEPTH - 1)) ? '0 : head_reg + 1'b1;
    if (push)
      tail_next = (tail_reg == IDX_W'(FL_DEPTH - 1)) ? '0 : tail_reg + 1'b1;
    case ({push, alloc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= CNT_W'(FL_DEPTH);
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // x0 is never written because allocation requires rd != 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rat_reg[i] <= PREG_W'(i);
    end else if (alloc) begin
      rat_reg[i_rd] <= alloc_preg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) fl_reg[i] <= PREG_W'(32 + i);
    end else if (push) begin
      fl_reg[tail_reg] <= i_commit_preg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_pc        <= '0;
      o_immediate <= '0;
      o_ALUsrc    <= 1'b0;
      o_Branch    <= 1'b0;
      o_ALUOp     <= '0;
      o_FUtype    <= '0;
      o_Memread   <= 1'b0;
      o_Memwrite  <= 1'b0;
      o_Regwrite  <= 1'b0;
      o_prs1      <= '0;
      o_prs2      <= '0;
      o_prd       <= '0;
      o_old_prd   <= '0;
    end else if (accept) begin
      o_valid     <= 1'b1;
      o_pc        <= i_pc;
      o_immediate <= i_immediate;
      o_ALUsrc    <= i_ALUsrc;
      o_Branch    <= i_Branch;
      o_ALUOp     <= i_ALUOp;
      o_FUtype    <= i_FUtype;
      o_Memread   <= i_Memread;
      o_Memwrite  <= i_Memwrite;
      o_Regwrite  <= i_Regwrite;
      o_prs1      <= rat_reg[i_rs1];
      o_prs2      <= rat_reg[i_rs2];
      o_prd       <= alloc ? alloc_preg : '0;
      o_old_prd   <= alloc ? rat_reg[i_rd] : '0;
    end else if (i_ready) begin
      o_valid     <= 1'b0;
    end
  end

  // Returning a register into a full list means the ROB freed something twice.
  assert property (@(posedge clk) disable iff (rst)
    !(i_commit_valid && (i_commit_preg != '0) && fl_full));

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios plus randomized traffic checked against
// a queue-based model of the RAT, free list and output slot.
module tb_rename_stage;
  localparam int NP  = 64;
  localparam int PW  = 6;
  localparam int FLD = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0, i_ready = 1'b1;
  logic [8:0]    i_pc = '0;
  logic [4:0]    i_rs1 = '0, i_rs2 = '0, i_rd = '0;
  logic [31:0]   i_immediate = '0;
  logic          i_ALUsrc = 0, i_Branch = 0, i_Memread = 0, i_Memwrite = 0, i_Regwrite = 0;
  logic [1:0]    i_ALUOp = '0, i_FUtype = '0;
  logic          i_commit_valid = 1'b0;
  logic [PW-1:0] i_commit_preg = '0;
  logic          o_ready, o_valid;
  logic [8:0]    o_pc;
  logic [31:0]   o_immediate;
  logic          o_ALUsrc, o_Branch, o_Memread, o_Memwrite, o_Regwrite;
  logic [1:0]    o_ALUOp, o_FUtype;
  logic [PW-1:0] o_prs1, o_prs2, o_prd, o_old_prd;

  rename_stage #(.NUM_PREGS(NP)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_immediate(i_immediate),
    .i_ALUsrc(i_ALUsrc), .i_Branch(i_Branch), .i_Memread(i_Memread),
    .i_Memwrite(i_Memwrite), .i_Regwrite(i_Regwrite), .i_ALUOp(i_ALUOp),
    .i_FUtype(i_FUtype), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_immediate(o_immediate), .o_ALUsrc(o_ALUsrc), .o_Branch(o_Branch),
    .o_ALUOp(o_ALUOp), .o_FUtype(o_FUtype), .o_Memread(o_Memread),
    .o_Memwrite(o_Memwrite), .o_Regwrite(o_Regwrite), .o_prs1(o_prs1),
    .o_prs2(o_prs2), .o_prd(o_prd), .o_old_prd(o_old_prd),
    .i_commit_valid(i_commit_valid), .i_commit_preg(i_commit_preg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [8:0]    pc;
    logic [31:0]   imm;
    logic          alusrc, branch, memread, memwrite, regwrite;
    logic [1:0]    aluop, futype;
    logic [PW-1:0] prs1, prs2, prd, old_prd;
  } out_t;

  int   rat[32];
  int   fl[$];
  int   pend[$];
  out_t m_out;
  int   checks = 0;
  int   failures = 0;
  logic [8:0] pc_ctr = '0;

  function automatic out_t dut_out();
    return {o_valid, o_pc, o_immediate, o_ALUsrc, o_Branch, o_Memread, o_Memwrite,
            o_Regwrite, o_ALUOp, o_FUtype, o_prs1, o_prs2, o_prd, o_old_prd};
  endfunction

  function automatic bit model_ready();
    return (!m_out.valid || i_ready) && (fl.size() != 0);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) rat[i] = i;
    fl.delete();
    for (int i = 32; i < NP; i++) fl.push_back(i);
    pend.delete();
    m_out = '0;
  endfunction

  // Applies one clock edge of architectural behaviour to the model.
  function automatic void model_step();
    bit rdy  = model_ready();
    bit full = (fl.size() >= FLD);
    int p;
    if (i_valid && rdy) begin
      m_out.valid = 1'b1;
      m_out.pc = i_pc; m_out.imm = i_immediate;
      m_out.alusrc = i_ALUsrc; m_out.branch = i_Branch; m_out.memread = i_Memread;
      m_out.memwrite = i_Memwrite; m_out.regwrite = i_Regwrite;
      m_out.aluop = i_ALUOp; m_out.futype = i_FUtype;
      m_out.prs1 = PW'(rat[i_rs1]);
      m_out.prs2 = PW'(rat[i_rs2]);
      if (i_Regwrite && i_rd != 0) begin
        p = fl.pop_front();
        m_out.prd = PW'(p);
        m_out.old_prd = PW'(rat[i_rd]);
        pend.push_back(rat[i_rd]);
        rat[i_rd] = p;
      end else begin
        m_out.prd = '0;
        m_out.old_prd = '0;
      end
      $display("txn pc=%0d rs1=x%0d rs2=x%0d rd=x%0d prs1=%0d prs2=%0d prd=%0d old_prd=%0d",
               i_pc, i_rs1, i_rs2, i_rd, m_out.prs1, m_out.prs2, m_out.prd, m_out.old_prd);
    end else if (i_ready) begin
      m_out.valid = 1'b0;
    end
    if (i_commit_valid && i_commit_preg != 0 && !full) fl.push_back(int'(i_commit_preg));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0; i_ready = 1'b1; i_commit_valid = 1'b0; i_commit_preg = '0;
  endtask

  task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit rw, input logic [31:0] imm,
                       input bit mw);
    i_valid = v; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_Regwrite = rw;
    i_immediate = imm; i_Memwrite = mw; i_Memread = 1'b0; i_Branch = 1'b0;
    i_ALUsrc = (imm != 0); i_ALUOp = rw ? 2'b10 : 2'b00; i_FUtype = mw ? 2'b10 : 2'b00;
    i_pc = pc_ctr; pc_ctr = pc_ctr + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (dut_out() !== out_t'('0)) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", dut_out());
    end
    checks++;
    if (o_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", o_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    drive(1, 5'd2, 5'd3, 5'd1, 1, 32'd0, 0);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL add_ready got=%b exp=1", o_ready); end
    tick();
    drive(1, 5'd1, 5'd0, 5'd4, 1, 32'd100, 0);
    @(negedge clk);
    checks++;
    if ({o_valid, o_prs1, o_prs2, o_prd, o_old_prd} !== {1'b1, 6'd2, 6'd3, 6'd32, 6'd1}) begin
      failures++;
      $display("FAIL add_map got v=%b prs1=%0d prs2=%0d prd=%0d old=%0d exp 1/2/3/32/1",
               o_valid, o_prs1, o_prs2, o_prd, o_old_prd);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({o_prs1, o_prd, o_old_prd} !== {6'd32, 6'd33, 6'd4}) begin
      failures++;
      $display("FAIL addi_chain got prs1=%0d prd=%0d old=%0d exp 32/33/4", o_prs1, o_prd, o_old_prd);
    end
    checks++;
    if (dut_out() !== m_out) begin
      failures++; $display("FAIL addi_bundle got=%h exp=%h", dut_out(), m_out);
    end
    tick();
  endtask

  task automatic test_nonwriters();
    do_reset();
    drive(1, 5'd9, 5'd8, 5'd12, 0, 32'd12, 1);
    tick();
    drive(1, 5'd0, 5'd0, 5'd0, 1, 32'd1, 0);
    @(negedge clk);
    checks++;
    if ({o_prs1, o_prs2, o_prd, o_old_prd} !== {6'd9, 6'd8, 6'd0, 6'd0}) begin
      failures++;
      $display("FAIL sw_map got prs1=%0d prs2=%0d prd=%0d old=%0d exp 9/8/0/0",
               o_prs1, o_prs2, o_prd, o_old_prd);
    end
    tick();
    drive(1, 5'd6, 5'd7, 5'd5, 1, 32'd0, 0);
    @(negedge clk);
    checks++;
    if ({o_prs1, o_prd, o_old_prd} !== {6'd0, 6'd0, 6'd0}) begin
      failures++;
      $display("FAIL x0_map got prs1=%0d prd=%0d old=%0d exp 0/0/0", o_prs1, o_prd, o_old_prd);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({o_prd, o_old_prd} !== {6'd32, 6'd5}) begin
      failures++; $display("FAIL no_pop got prd=%0d old=%0d exp 32/5", o_prd, o_old_prd);
    end
    tick();
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int k = 0; k < FLD; k++) begin
      drive(1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'(1 + k % 31), 1, 32'd0, 0);
      @(negedge clk);
      checks++;
      if (dut_out() !== m_out || o_ready !== model_ready()) begin
        failures++;
        $display("FAIL exhaust_fill k=%0d got=%h rdy=%b exp=%h rdy=%b",
                 k, dut_out(), o_ready, m_out, model_ready());
      end
      tick();
    end
    drive(1, 5'd1, 5'd2, 5'd7, 1, 32'd0, 0);
    i_commit_valid = 1'b1; i_commit_preg = 6'd1;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0) begin failures++; $display("FAIL empty_ready got=%b exp=0", o_ready); end
    tick();
    i_commit_valid = 1'b0; i_commit_preg = '0;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL refill_ready got=%b exp=1", o_ready); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({o_valid, o_prd} !== {1'b1, 6'd1}) begin
      failures++; $display("FAIL reuse_prd got v=%b prd=%0d exp 1/1", o_valid, o_prd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_t snap;
    do_reset();
    drive(1, 5'd1, 5'd1, 5'd2, 1, 32'd0, 0);
    tick();
    snap = m_out;
    drive(1, 5'd2, 5'd0, 5'd3, 1, 32'd7, 0);
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (dut_out() !== snap || o_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got=%h rdy=%b exp=%h rdy=0", c, dut_out(), o_ready, snap);
      end
      tick();
    end
    i_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL resume_ready got=%b exp=1", o_ready); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({o_valid, o_prs1, o_prd, o_old_prd} !== {1'b1, 6'd32, 6'd33, 6'd3}) begin
      failures++;
      $display("FAIL resume_map got v=%b prs1=%0d prd=%0d old=%0d exp 1/32/33/3",
               o_valid, o_prs1, o_prd, o_old_prd);
    end
    tick();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL drain got=%b exp=0", o_valid); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom), 5'($urandom),
            $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 4) == 0);
      i_Branch = 1'($urandom); i_Memread = 1'($urandom);
      i_ALUOp = 2'($urandom); i_FUtype = 2'($urandom_range(0, 2));
      i_ready = ($urandom_range(0, 3) != 0);
      i_commit_valid = 1'b0; i_commit_preg = '0;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        i_commit_valid = 1'b1; i_commit_preg = PW'(pend.pop_front());
      end else if ($urandom_range(0, 19) == 0) begin
        i_commit_valid = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (dut_out() !== m_out || o_ready !== model_ready()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h rdy=%b exp=%h rdy=%b",
                 c, dut_out(), o_ready, m_out, model_ready());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'd4, 5'd5, 5'(10 + k), 1, 32'd0, 0);
      tick();
    end
    idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_out() !== out_t'('0)) begin
      failures++; $display("FAIL async_clear got=%h exp=0", dut_out());
    end
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    drive(1, 5'd5, 5'd7, 5'd3, 1, 32'd0, 0);
    #1;
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", o_ready); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({o_valid, o_prs1, o_prs2, o_prd, o_old_prd} !== {1'b1, 6'd5, 6'd7, 6'd32, 6'd3}) begin
      failures++;
      $display("FAIL post_rst_map got v=%b prs1=%0d prs2=%0d prd=%0d old=%0d exp 1/5/7/32/3",
               o_valid, o_prs1, o_prs2, o_prd, o_old_prd);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nonwriters();
    test_exhaust();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
